// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// The sequencer owns the selects and enables; the datapath returns the IR, Zero and memory ready.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUCtrl;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  instr, eq, mem_ready,
        output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, ResultSrc, ImmSrc,
               illegal, state, instret
    );

    modport slave (
        output instr, eq, mem_ready,
        input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, ResultSrc, ImmSrc,
               illegal, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer that time-shares one ALU and one memory port of an RV32I datapath,
// walking each instruction through fetch/decode/execute/memory/writeback.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4, IR load on mem_ready
//   DECODE   | OldPC+imm into ALUOut (branch/jump target), dispatch
//   MEMADR   | rs1+imm into ALUOut (load/store address)
//   MEMREAD  | read data memory at ALUOut, wait for mem_ready
//   MEMWB    | write ReadData to rd
//   MEMWRITE | write rs2 to data memory at ALUOut, wait for mem_ready
//   EXECR    | rs1 op rs2
//   EXECI    | rs1 op imm
//   ALUWB    | write ALUOut to rd
//   JAL      | PC <= target in ALUOut, ALUOut <= OldPC+4
//   BRANCH   | compare rs1/rs2, conditional PC load from ALUOut
//   TRAP     | unsupported encoding, parked until reset
module multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_if.master      bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;

    logic        alu_ok;
    logic [2:0]  alu_op;

    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl, imm_src;
    logic        retire;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign funct7_b5 = bus.instr[30];

    // Shared by EXECR and EXECI; sub only exists in the register form.
    always_comb begin
        alu_ok = 1'b1;
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (state_q == S_EXECR && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_STORE:  imm_src = IMM_S;
                    OP_BRANCH: imm_src = IMM_B;
                    OP_JAL:    imm_src = IMM_J;
                    default:   imm_src = IMM_I;
                endcase
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = opcode[5] ? IMM_S : IMM_I;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_RDATA;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                if (alu_ok) begin
                    alu_ctrl = alu_op;
                    state_d  = S_ALUWB;
                end else begin
                    state_d  = S_TRAP;
                end
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_ctrl  = ALU_SUB;
                case (funct3)
                    3'b000: begin
                        pc_write = bus.eq;
                        state_d  = S_FETCH;
                    end
                    3'b001: begin
                        pc_write = ~bus.eq;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                     state_q == S_ALUWB || state_q == S_BRANCH);

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    always_comb begin
        bus.PCWrite   = rst_n & pc_write;
        bus.IRWrite   = rst_n & ir_write;
        bus.AdrSrc    = rst_n & adr_src;
        bus.MemRead   = rst_n & mem_read;
        bus.MemWrite  = rst_n & mem_write;
        bus.RegWrite  = rst_n & reg_write;
        bus.ALUSrcA   = rst_n ? alu_src_a  : 2'b00;
        bus.ALUSrcB   = rst_n ? alu_src_b  : 2'b00;
        bus.ALUCtrl   = rst_n ? alu_ctrl   : 3'b000;
        bus.ResultSrc = rst_n ? result_src : 2'b00;
        bus.ImmSrc    = rst_n ? imm_src    : 3'b000;
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;
    assign bus.illegal = illegal_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the RV32I datapath (register file, ALU, data memory, source and result muxes), turning it into a multi-cycle machine that shares one ALU and one memory port across instruction phases. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write-enable, stalls on a memory ready handshake, traps on unsupported encodings and counts retired instructions.

## Interface
- No parameters; widths are fixed by RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents; valid from DECODE onward
- eq  in  1  ALU Zero flag
- mem_ready  in  1  memory completes the requested read or write this cycle
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  ALU operand B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ALUCtrl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J
- illegal  out  1  sticky trap flag
- state  out  4  current FSM state, for debug
- instret  out  32  retired-instruction counter

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, TRAP=15.

Per-state behaviour:
- FETCH:
  - Drives MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUCtrl=add, ResultSrc=10.
  - Holds while mem_ready=0.
  - When mem_ready=1, asserts IRWrite=1 and PCWrite=1 in that same cycle, then goes to DECODE.
- DECODE:
  - Computes the branch/jump target: ALUSrcA=01, ALUSrcB=01, add, with ImmSrc taken from the opcode.
  - Dispatches on the opcode: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BRANCH; 1101111 to JAL.
  - Any other opcode goes to TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc = I for loads and S for stores. Then goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, then FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. Waits for mem_ready, then FETCH.
- EXECR / EXECI: ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI). ALUCtrl comes from the funct decode below. Then ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, then FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (loads the target held in ALUOut).
  - Goes to ALUWB, which writes PC+4 to rd.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=eq when funct3=000 (beq), PCWrite=~eq when funct3=001 (bne).
  - Any other funct3 goes to TRAP with no PC write; otherwise goes to FETCH.
- TRAP: illegal=1 and all enables 0. The FSM stays in TRAP until reset.

Funct decode (EXECR/EXECI):
- funct3 000: add, or sub when EXECR and funct7[5]=1.
- funct3 010: slt (101).
- funct3 110: or (011).
- funct3 111: and (010).
- Any other funct3 goes to TRAP instead of ALUWB, with no RegWrite.

Enable rule: enables not listed for a state are 0. Select outputs not listed are don't-care; drive them as 0.

instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rst_n low) is asynchronous:
  - state=FETCH, instret=0, illegal=0.
  - PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced to 0 while rst_n=0.
  - All selects are 0 during reset.
  - The first FETCH request goes out in the first cycle after rst_n rises.
- Reset mid-operation (for example during MEMWRITE awaiting mem_ready) aborts the instruction immediately. No further enables are issued, and instret does not count the aborted instruction.
- Latency with mem_ready=1 every cycle:
  - Load: 5 cycles.
  - Store, R-type, I-type, jal: 4 cycles.
  - Branch: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Request signals stay asserted, and their values stay stable, until the ready cycle.
- mem_ready is ignored in all other states.
- All outputs are combinational from state, instr, eq and mem_ready. No output depends on a value registered inside this block except state, instret and illegal.

## Test plan
- Reset, then lw x5,8(x0) with mem_ready low for 2 cycles in both FETCH and MEMREAD → states 0,0,0,1,2,3,3,3,4,0. RegWrite=1 only in MEMWB, with ResultSrc=01. instret=1.
- add then sub (funct7=0100000) as R-type, mem_ready tied high → ALUCtrl=000 then 001 in EXECR. Each takes 4 cycles. instret=2.
- beq with eq=1, then with eq=0; then bne with eq=0 → PCWrite in BRANCH is 1, 0, 1 respectively. Each takes 3 cycles.
- jal x1,+16 → DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=011. JAL: PCWrite=1. ALUWB: RegWrite=1.
- Opcode 0x7F, then rst_n pulsed → state=15 and illegal=1 with no enables held over 10 cycles. After reset: illegal=0, state=0.
- sw with mem_ready held low, rst_n asserted mid-wait → MemWrite drops to 0 asynchronously, state=0, instret unchanged at its pre-store value (0 after reset).
